// File: rtl/pokey_audio_core.sv
// POKEY-style audio core: tick-enabled prescalers, per-channel dividers, poly noise, registered mix.
// Define POKEY_AUDIO_PWM_EN to add a 1-bit PWM rendering of the mix on pwm_out.
module pokey_audio_core #(
  parameter int unsigned NUM_CHAN = 4,
  parameter int unsigned FREQ_W   = 8,
  parameter int unsigned DIV179   = 15,
  parameter int unsigned DIV64    = 422,
  parameter int unsigned DIV16    = 1688,
  localparam int unsigned MixW    = 4 + $clog2(NUM_CHAN)
) (
  input  logic                  mainClock,
  input  logic                  init,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [15:0]           wr_data,
  output logic [NUM_CHAN-1:0]   audio,
  output logic [4*NUM_CHAN-1:0] vol,
`ifdef POKEY_AUDIO_PWM_EN
  output logic                  pwm_out,
`endif
  output logic [MixW-1:0]       mix
);

  localparam int unsigned W179 = $clog2(DIV179 + 1);
  localparam int unsigned W64  = $clog2(DIV64 + 1);
  localparam int unsigned W16  = $clog2(DIV16 + 1);

  logic [W179-1:0] pre179_q;
  logic [W64-1:0]  pre64_q;
  logic [W16-1:0]  pre16_q;
  logic            tick179, tick64, tick16;

  logic [FREQ_W-1:0] audf_q [NUM_CHAN];
  logic [7:0]        audc_q [NUM_CHAN];
  logic              ctl_poly9_q, ctl_slow_q;
  logic [NUM_CHAN-1:0] fastmask_q;

  logic [3:0]  poly4_q;
  logic [4:0]  poly5_q;
  logic [8:0]  poly9_q;
  logic [16:0] poly17_q;
  logic        noise_msb;

  logic [FREQ_W-1:0]   cnt_q [NUM_CHAN];
  logic [FREQ_W-1:0]   cnt_d [NUM_CHAN];
  logic [NUM_CHAN-1:0] sel_tick, pulse, audio_d, audio_q;
  logic [MixW-1:0]     mix_d, mix_q;

  logic [2:0] wr_chan;
  logic [1:0] wr_sel;
  logic       unused_wr;

  always_comb begin
    wr_chan   = wr_addr[4:2];
    wr_sel    = wr_addr[1:0];
    unused_wr = ^wr_data;
    tick179   = (pre179_q == W179'(DIV179 - 1));
    tick64    = (pre64_q == W64'(DIV64 - 1));
    tick16    = (pre16_q == W16'(DIV16 - 1));
    noise_msb = ctl_poly9_q ? poly9_q[8] : poly17_q[16];
  end

  always_ff @(posedge mainClock) begin
    if (init) begin
      pre179_q <= '0;
      pre64_q  <= '0;
      pre16_q  <= '0;
    end else begin
      pre179_q <= tick179 ? '0 : pre179_q + 1'b1;
      pre64_q  <= tick64 ? '0 : pre64_q + 1'b1;
      pre16_q  <= tick16 ? '0 : pre16_q + 1'b1;
    end
  end

  // Writes landing with init are dropped; out-of-range channels match no slot.
  always_ff @(posedge mainClock) begin
    if (init) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        audf_q[i] <= '0;
        audc_q[i] <= '0;
      end
      ctl_poly9_q <= 1'b0;
      ctl_slow_q  <= 1'b0;
      fastmask_q  <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        2'd0: begin
          for (int i = 0; i < NUM_CHAN; i++) begin
            if (wr_chan == 3'(i)) audf_q[i] <= wr_data[FREQ_W-1:0];
          end
        end
        2'd1: begin
          for (int i = 0; i < NUM_CHAN; i++) begin
            if (wr_chan == 3'(i)) audc_q[i] <= wr_data[7:0];
          end
        end
        2'd2: begin
          ctl_poly9_q <= wr_data[7];
          ctl_slow_q  <= wr_data[0];
        end
        default: fastmask_q <= wr_data[NUM_CHAN-1:0];
      endcase
    end
  end

  always_ff @(posedge mainClock) begin
    if (init) begin
      poly4_q  <= '1;
      poly5_q  <= '1;
      poly9_q  <= '1;
      poly17_q <= '1;
    end else if (tick179) begin
      poly4_q  <= {poly4_q[2:0], poly4_q[3] ^ poly4_q[2]};
      poly5_q  <= {poly5_q[3:0], poly5_q[4] ^ poly5_q[2]};
      poly9_q  <= {poly9_q[7:0], poly9_q[8] ^ poly9_q[4]};
      poly17_q <= {poly17_q[15:0], poly17_q[16] ^ poly17_q[11]};
    end
  end

  // Pulses evaluate the AUDC value held before any same-cycle write.
  always_comb begin
    for (int i = 0; i < NUM_CHAN; i++) begin
      sel_tick[i] = fastmask_q[i] ? tick179 : (ctl_slow_q ? tick16 : tick64);
      pulse[i]    = sel_tick[i] && (cnt_q[i] == '0);
      cnt_d[i]    = cnt_q[i];
      if (sel_tick[i]) cnt_d[i] = pulse[i] ? audf_q[i] : cnt_q[i] - 1'b1;
      audio_d[i] = audio_q[i];
      if (audc_q[i][4]) begin
        audio_d[i] = 1'b1;
      end else if (pulse[i] && (audc_q[i][7] || poly5_q[4])) begin
        if (audc_q[i][5]) audio_d[i] = ~audio_q[i];
        else              audio_d[i] = audc_q[i][6] ? poly4_q[3] : noise_msb;
      end
    end
  end

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (audio_q[i]) mix_d = mix_d + MixW'(audc_q[i][3:0]);
    end
  end

  always_ff @(posedge mainClock) begin
    if (init) begin
      for (int i = 0; i < NUM_CHAN; i++) cnt_q[i] <= '0;
      audio_q <= '0;
      mix_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) cnt_q[i] <= cnt_d[i];
      audio_q <= audio_d;
      mix_q   <= mix_d;
    end
  end

  always_comb begin
    audio = audio_q;
    mix   = mix_q;
    for (int i = 0; i < NUM_CHAN; i++) vol[4*i +: 4] = audc_q[i][3:0];
  end

`ifdef POKEY_AUDIO_PWM_EN
  logic [MixW-1:0] pwm_ctr_q;
  logic            pwm_q;

  always_ff @(posedge mainClock) begin
    if (init) begin
      pwm_ctr_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_ctr_q <= pwm_ctr_q + 1'b1;
      pwm_q     <= (pwm_ctr_q < mix_q);
    end
  end

  always_comb pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_pokey_audio_core.sv
// Randomised bench for pokey_audio_core: per-cycle comparison against a recurrence-based model,
// plus literal checks for reset, tone period, volume-only, reload timing, poly length, bad writes.
module tb_pokey_audio_core;
  localparam int unsigned NUM_CHAN = 4;
  localparam int unsigned FREQ_W   = 8;
  localparam int unsigned DIV179   = 2;
  localparam int unsigned DIV64    = 5;
  localparam int unsigned DIV16    = 7;
  localparam int unsigned MIX_W    = 4 + $clog2(NUM_CHAN);

  logic clk = 1'b0;
  logic init = 1'b1;
  logic wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [NUM_CHAN-1:0] audio;
  logic [4*NUM_CHAN-1:0] vol;
  logic [MIX_W-1:0] mix;
`ifdef POKEY_AUDIO_PWM_EN
  logic pwm_out;
`endif

  always #5 clk = ~clk;

  pokey_audio_core #(
    .NUM_CHAN(NUM_CHAN), .FREQ_W(FREQ_W), .DIV179(DIV179), .DIV64(DIV64), .DIV16(DIV16)
  ) dut (
    .mainClock(clk),
    .init     (init),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .audio    (audio),
    .vol      (vol),
`ifdef POKEY_AUDIO_PWM_EN
    .pwm_out  (pwm_out),
`endif
    .mix      (mix)
  );

  int tests = 0;
  int fails = 0;

  // Model state: registers, ticks-to-next-pulse, and poly sequences as bit histories.
  bit m_valid = 1'b0;
  int cyc;
  int m_audf [NUM_CHAN];
  logic [7:0] m_audc [NUM_CHAN];
  logic [7:0] m_ctl;
  logic [NUM_CHAN-1:0] m_fm;
  int m_rem [NUM_CHAN];
  logic [NUM_CHAN-1:0] m_audio;
  int m_mix;
  int m_ctr;
  bit m_pwm;
  bit h4[$], h5[$], h9[$], h17[$];

  // Sequence s[n] = s[n-deg] ^ s[n-tap]; queue holds the last deg terms, oldest first.
  function automatic bit next_term(bit q[$], int deg, int tap);
    return q[0] ^ q[deg - tap];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit t179, t64, t16, sel, pul, nb, noise;
    logic [NUM_CHAN-1:0] na;
    int nmix, chan;
    bit npwm;
    if (init) begin
      m_valid = 1'b1;
      cyc = 0;
      m_ctl = '0;
      m_fm = '0;
      m_audio = '0;
      m_mix = 0;
      m_ctr = 0;
      m_pwm = 1'b0;
      for (int i = 0; i < NUM_CHAN; i++) begin
        m_audf[i] = 0;
        m_audc[i] = '0;
        m_rem[i] = 0;
      end
      h4.delete(); h5.delete(); h9.delete(); h17.delete();
      repeat (4) h4.push_back(1'b1);
      repeat (5) h5.push_back(1'b1);
      repeat (9) h9.push_back(1'b1);
      repeat (17) h17.push_back(1'b1);
      return;
    end
    t179 = (cyc % DIV179) == DIV179 - 1;
    t64  = (cyc % DIV64) == DIV64 - 1;
    t16  = (cyc % DIV16) == DIV16 - 1;
    noise = m_ctl[7] ? h9[0] : h17[0];
    nmix = 0;
    for (int i = 0; i < NUM_CHAN; i++) if (m_audio[i]) nmix += int'(m_audc[i][3:0]);
    npwm = m_ctr < m_mix;
    for (int i = 0; i < NUM_CHAN; i++) begin
      sel = m_fm[i] ? t179 : (m_ctl[0] ? t16 : t64);
      pul = 1'b0;
      if (sel) begin
        if (m_rem[i] == 0) begin
          pul = 1'b1;
          m_rem[i] = m_audf[i];
        end else begin
          m_rem[i]--;
        end
      end
      na[i] = m_audio[i];
      if (m_audc[i][4]) na[i] = 1'b1;
      else if (pul && (m_audc[i][7] || h5[0])) begin
        if (m_audc[i][5]) na[i] = ~m_audio[i];
        else na[i] = m_audc[i][6] ? h4[0] : noise;
      end
    end
    if (t179) begin
      nb = next_term(h4, 4, 3);   h4.push_back(nb);  void'(h4.pop_front());
      nb = next_term(h5, 5, 3);   h5.push_back(nb);  void'(h5.pop_front());
      nb = next_term(h9, 9, 5);   h9.push_back(nb);  void'(h9.pop_front());
      nb = next_term(h17, 17, 12); h17.push_back(nb); void'(h17.pop_front());
    end
    if (wr_en) begin
      chan = int'(wr_addr[4:2]);
      case (wr_addr[1:0])
        2'd0: if (chan < NUM_CHAN) m_audf[chan] = int'(wr_data[FREQ_W-1:0]);
        2'd1: if (chan < NUM_CHAN) m_audc[chan] = wr_data[7:0];
        2'd2: m_ctl = wr_data[7:0];
        default: m_fm = wr_data[NUM_CHAN-1:0];
      endcase
    end
    m_audio = na;
    m_mix = nmix;
    m_pwm = npwm;
    m_ctr = (m_ctr + 1) % (1 << MIX_W);
    cyc++;
  endtask

  task automatic compare();
    logic [4*NUM_CHAN-1:0] ev;
    if (!m_valid) return;
    for (int i = 0; i < NUM_CHAN; i++) ev[4*i +: 4] = m_audc[i][3:0];
    check("audio", 32'(audio), 32'(m_audio));
    check("vol", 32'(vol), 32'(ev));
    check("mix", 32'(mix), 32'(m_mix));
`ifdef POKEY_AUDIO_PWM_EN
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  // Reset with junk writes held against init; they must be dropped.
  task automatic do_reset();
    init = 1'b1;
    repeat (3) begin
      wr_en = 1'b1;
      wr_addr = 5'($urandom);
      wr_data = 16'($urandom);
      cycle();
    end
    init = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic next_toggle(output int n);
    logic prev;
    int k;
    prev = audio[0];
    n = -1;
    k = 0;
    while (n < 0 && k < 400) begin
      cycle();
      k++;
      if (audio[0] !== prev) n = k;
    end
  endtask

  bit samp [1100];

  initial begin
    int n, ones, mm;
    logic a;
    logic [4:0] ra;
    logic [15:0] rd;

    // Reset after ordinary garbage writes.
    cycle();
    init = 1'b0;
    for (int i = 0; i < 8; i++) wr(5'($urandom), 16'($urandom));
    do_reset();
    check("rst_audio", 32'(audio), 32'h0);
    check("rst_mix", 32'(mix), 32'h0);
    check("rst_vol", 32'(vol), 32'h0);
    check("rst_poly17", 32'(dut.poly17_q), 32'h1FFFF);

    // Pure tone on the fast tick.
    do_reset();
    wr(5'b00011, 16'h0001);
    wr(5'b00000, 16'h0003);
    wr(5'b00001, 16'h00A8);
    repeat (20) cycle();
    next_toggle(n);
    for (int k = 0; k < 4; k++) begin
      next_toggle(n);
      check("tone_period", 32'(n), 32'd8);
    end
    a = audio[0];
    cycle();
    check("tone_mix_lag", 32'(mix), a ? 32'd8 : 32'd0);

    // Volume-only on every channel.
    do_reset();
    for (int i = 0; i < NUM_CHAN; i++) wr({3'(i), 2'b01}, 16'h001F);
    repeat (3) cycle();
    check("volonly_audio", 32'(audio), 32'hF);
    check("volonly_mix", 32'(mix), 32'd60);
    wr(5'b00000, 16'd5);
    wr(5'b00100, 16'd200);
    repeat (30) cycle();
    check("volonly_mix_after_audf", 32'(mix), 32'd60);

    // AUDF rewritten while the counter sits at 5.
    do_reset();
    wr(5'b00011, 16'h0001);
    wr(5'b00000, 16'd10);
    wr(5'b00001, 16'h00A8);
    repeat (30) cycle();
    next_toggle(n);
    next_toggle(n);
    check("reload_period_22", 32'(n), 32'd22);
    repeat (10) cycle();
    wr(5'b00000, 16'd2);
    next_toggle(n);
    check("reload_pending", 32'(n), 32'd11);
    next_toggle(n);
    check("reload_new_a", 32'(n), 32'd6);
    next_toggle(n);
    check("reload_new_b", 32'(n), 32'd6);

    // Poly9 through audio[0], one sample per fast tick.
    do_reset();
    wr(5'b00011, 16'h0001);
    wr(5'b00010, 16'h0080);
    wr(5'b00001, 16'h0088);
    repeat (20) cycle();
    for (int k = 0; k < 1100; k++) begin
      cycle();
      cycle();
      samp[k] = audio[0];
    end
    mm = 0;
    ones = 0;
    for (int k = 0; k < 511; k++) begin
      if (samp[k] != samp[k+511]) mm++;
      if (samp[k]) ones++;
    end
    check("poly9_period_511", 32'(mm), 32'd0);
    check("poly9_ones", 32'(ones), 32'd256);
    mm = 0;
    for (int k = 0; k < 511; k++) if (samp[k] != samp[k+73]) mm++;
    check("poly9_not_73", 32'(mm != 0), 32'd1);

    // Poly17 must not repeat at 511.
    wr(5'b00010, 16'h0000);
    for (int k = 0; k < 1100; k++) begin
      cycle();
      cycle();
      samp[k] = audio[0];
    end
    mm = 0;
    for (int k = 0; k < 511; k++) if (samp[k] != samp[k+511]) mm++;
    check("poly17_not_511", 32'(mm != 0), 32'd1);

    // Writes to channels beyond NUM_CHAN leave state alone.
    do_reset();
    wr(5'b00001, 16'h0005);
    wr(5'b10101, 16'h001F);
    wr(5'b11101, 16'h00FF);
    wr(5'b11100, 16'h0033);
    cycle();
    check("oob_vol", 32'(vol), 32'h0005);

`ifdef POKEY_AUDIO_PWM_EN
    do_reset();
    wr(5'b00001, 16'h0018);
    repeat (10) cycle();
    ones = 0;
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (pwm_out) ones++;
    end
    check("pwm_duty", 32'(ones), 32'd8);
`endif

    // Random traffic against the model.
    do_reset();
    for (int it = 0; it < 5000; it++) begin
      n = int'($urandom_range(0, 199));
      if (n == 0) begin
        init = 1'b1;
        cycle();
        init = 1'b0;
      end else if (n < 40) begin
        ra = 5'($urandom);
        rd = 16'($urandom);
        if (ra[1:0] == 2'd0 && $urandom_range(0, 3) != 0) rd = rd & 16'h000F;
        wr(ra, rd);
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
